// File: rtl/flopr_pkg.sv
// flopr_pkg
//
// Shared constants and types for the flopr register family.
//
// Contents:
//   FLOPR_DEFAULT_WIDTH  width of a register built for the machine word
//   FLOPR_MAX_WIDTH      widest register the flopr block supports
//   word_t               a machine word, for users of the default width
//   flopr_width_legal()  true when a requested width is supported
//
// Optional feature macro: FLOPR_ASSERT_EN (used by flopr, not by this file).

package flopr_pkg;

    localparam int FLOPR_DEFAULT_WIDTH = 64;
    localparam int FLOPR_MAX_WIDTH     = 128;

    typedef logic [63:0] word_t;

    // A width is usable when it holds at least one bit and does not
    // exceed the widest register the datapath expects to build.
    function automatic logic flopr_width_legal(input int n);
        return (n >= 1) && (n <= FLOPR_MAX_WIDTH);
    endfunction

endpackage : flopr_pkg

// File: rtl/flopr_cell.sv
// flopr_cell
//
// A single-bit D flip-flop with asynchronous, active-high reset to zero.
// It is the bit slice that flopr replicates to build a register of any
// width.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high clear
//   d      in   next-state bit
//   q      out  registered bit

module flopr_cell
    import flopr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic state_d;
    logic state_q;

    always_comb begin
        state_d = d;
    end

    // Reset is in the sensitivity list so that asserting it clears the bit
    // at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule : flopr_cell

// File: rtl/flopr.sv
// flopr
//
// Parameterised N-bit D register with asynchronous active-high reset to
// zero. Used for the program counter and for pipeline registers. On every
// rising edge of clk, q takes the value of d, unless reset is high, in
// which case q is held at zero regardless of the clock.
//
// Parameters:
//   N      register width in bits, 1..FLOPR_MAX_WIDTH (default 64)
//
// Ports (positional order d, clk, reset, q):
//   d      in   [N-1:0]  next-state data
//   clk    in            rising-edge clock
//   reset  in            asynchronous active-high clear
//   q      out  [N-1:0]  registered state
//
// Optional feature macro: FLOPR_ASSERT_EN
//   When defined, simulation-only checks are compiled in: q is zero while
//   reset is high, q follows d across consecutive out-of-reset edges,
//   reset is never X/Z, and N is within the supported range. Without the
//   macro the module is only the register, with identical behaviour.

module flopr
    import flopr_pkg::*;
#(
    parameter int N = FLOPR_DEFAULT_WIDTH
)
(
    input  logic [N-1:0] d,
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] q
);

    // One independent bit slice per data bit; there is no logic shared
    // between bits, so the register never truncates or extends anything.
    for (genvar i = 0; i < N; i++) begin : g_bit
        flopr_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .q     (q[i])
        );
    end

`ifdef FLOPR_ASSERT_EN

    // Width sanity, resolved when the design is elaborated.
    if (!flopr_width_legal(N)) begin : g_bad_width
        $error("%m: flopr width N=%0d outside 1..%0d", N, FLOPR_MAX_WIDTH);
    end

    // Whenever reset is seen high at an edge, the register must read zero.
    a_zero_in_reset : assert property (
        @(posedge clk) reset |-> (q == '0)
    ) else $error("%m: q nonzero while reset asserted");

    // With reset low at the previous and current edge, q now shows what
    // d held at the previous edge.
    a_load_follows_d : assert property (
        @(posedge clk) disable iff (reset)
        (!reset && !$past(reset)) |-> (q === $past(d))
    ) else $error("%m: q does not match d from the previous edge");

    // Reset must always be a clean 0 or 1.
    a_reset_known : assert property (
        @(posedge clk) !$isunknown(reset)
    ) else $error("%m: reset is X or Z");

`else
`endif

endmodule : flopr

// File: tb/tb_flopr.sv
// tb_flopr
//
// Self-checking bench for flopr. A 64-bit and a 1-bit instance share the
// clock and reset. Expected values come from a behavioural view of the
// register: after a rising edge q is zero if reset is high, otherwise the
// d that was presented; reset forces zero immediately; d changes between
// edges are invisible.

module tb_flopr;

    typedef struct {
        logic        rst;
        logic [63:0] d;
        logic [63:0] exp_q;
    } vec_t;

    logic        clk    = 1'b1;
    logic        reset  = 1'b1;
    logic [63:0] d64    = '0;
    logic [63:0] q64;
    logic        d1     = 1'b0;
    logic        q1;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t vecs[10];

    flopr #(.N(64)) dut64 (
        .d     (d64),
        .clk   (clk),
        .reset (reset),
        .q     (q64)
    );

    flopr #(.N(1)) dut1 (
        .d     (d1),
        .clk   (clk),
        .reset (reset),
        .q     (q1)
    );

    // 10-unit period, starting high; falling edges at 5, 15, ...
    always #5 clk = ~clk;

    // Drive new inputs on the falling edge, then step just past the next
    // rising edge so outputs are sampled away from the active edge.
    task automatic applyStimulus(input logic rst, input logic [63:0] dv);
        @(negedge clk);
        reset = rst;
        d64   = dv;
        d1    = dv[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Cycle-budget guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] model_q;
        logic        r;
        logic [63:0] dv;

        // Reset held for five cycles while d steps, then released with the
        // same sequence presented one value per cycle.
        vecs[0] = '{1'b1, 64'd13, 64'd0};
        vecs[1] = '{1'b1, 64'd69, 64'd0};
        vecs[2] = '{1'b1, 64'd8,  64'd0};
        vecs[3] = '{1'b1, 64'd11, 64'd0};
        vecs[4] = '{1'b1, 64'd5,  64'd0};
        vecs[5] = '{1'b0, 64'd13, 64'd13};
        vecs[6] = '{1'b0, 64'd69, 64'd69};
        vecs[7] = '{1'b0, 64'd8,  64'd8};
        vecs[8] = '{1'b0, 64'd11, 64'd11};
        vecs[9] = '{1'b0, 64'd5,  64'd5};

        @(negedge clk);
        checkOutput("reset_state_q64", q64, 64'd0);
        checkOutput("reset_state_q1", {63'd0, q1}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].d);
            checkOutput($sformatf("table_%0d", i), q64, vecs[i].exp_q);
            checkOutput($sformatf("table_%0d_n1", i), {63'd0, q1},
                        {63'd0, vecs[i].exp_q[0]});
        end

        // d moving between edges must not reach q.
        applyStimulus(1'b0, 64'hFF);
        checkOutput("load_ff", q64, 64'hFF);
        #1;
        d64 = 64'h00;
        d1  = 1'b0;
        #2;
        checkOutput("hold_between_edges", q64, 64'hFF);
        checkOutput("hold_between_edges_n1", {63'd0, q1}, 64'd1);
        applyStimulus(1'b0, 64'h00);
        checkOutput("load_00", q64, 64'h00);

        // Reset in the middle of a cycle clears at once and holds over an edge.
        applyStimulus(1'b0, 64'hDEADBEEFCAFEF00D);
        checkOutput("load_deadbeef", q64, 64'hDEADBEEFCAFEF00D);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_cycle_reset", q64, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", q64, 64'd0);
        applyStimulus(1'b0, 64'd7);
        checkOutput("load_after_release", q64, 64'd7);

        // Full-width patterns at both widths.
        applyStimulus(1'b0, '1);
        checkOutput("all_ones_n64", q64, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("all_ones_n1", {63'd0, q1}, 64'd1);
        applyStimulus(1'b0, '0);
        checkOutput("all_zeros_n64", q64, 64'd0);
        checkOutput("all_zeros_n1", {63'd0, q1}, 64'd0);

        // Randomised traffic with occasional reset and stray d changes.
        for (int k = 0; k < 300; k++) begin
            r  = ($urandom_range(0, 9) == 0);
            dv = {$urandom, $urandom};
            applyStimulus(r, dv);
            model_q = r ? 64'd0 : dv;
            checkOutput("rand_edge", q64, model_q);
            checkOutput("rand_edge_n1", {63'd0, q1}, {63'd0, model_q[0]});
            if ($urandom_range(0, 3) == 0) begin
                d64 = {$urandom, $urandom};
                d1  = d64[0];
                #1;
                checkOutput("rand_hold", q64, model_q);
            end
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                model_q = 64'd0;
                #1;
                checkOutput("rand_async_reset", q64, model_q);
                checkOutput("rand_async_reset_n1", {63'd0, q1}, 64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_flopr
